// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and FSM state type for the load/store unit
package lsu_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_load_format.sv
// rtl/lsu_load_format.sv - selects the addressed lane of a read word and sign/zero-extends it
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           offset,
  input  logic [WORD_SIZE-1:0] rdata,
  output logic [WORD_SIZE-1:0] data
);

  logic [WORD_SIZE-1:0] lane;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    data = rdata;
    case (funct3)
      LSU_LB:  data = {{24{lane[7]}}, lane[7:0]};
      LSU_LH:  data = {{16{lane[15]}}, lane[15:0]};
      LSU_LBU: data = {24'd0, lane[7:0]};
      LSU_LHU: data = {16'd0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-transaction data-memory access stage with req/ready handshake
// Optional ACCESS-state timeout abort: define LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int WORD_SIZE = lsu_pkg::WORD_SIZE
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] store_data,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] load_data,
  output logic                 err_misaligned,
  output logic                 err_illegal,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  import lsu_pkg::*;

  lsu_state_t           state, state_next;
  logic                 st_q, ill_q, mis_q;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic                 legal, misaligned, req_ok;
  logic [3:0]           be_new;
  logic [WORD_SIZE-1:0] wdata_new, fmt_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout;
  assign timeout = (state == ACCESS) && !mem_ready && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Request decode on the live inputs; only consumed when a start is accepted.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = store_data;
    if (is_store) legal = funct3 inside {LSU_SB, LSU_SH, LSU_SW};
    else          legal = funct3 inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_new     = 4'b0011 << {addr[1], 1'b0};
        wdata_new  = {2{store_data[15:0]}};
        misaligned = addr[0];
      end
      default: begin
        be_new     = 4'b1111;
        misaligned = |addr[1:0];
      end
    endcase
  end

  assign req_ok = legal && !misaligned;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = req_ok ? ACCESS : RESP;
      ACCESS: begin
        if (mem_ready) state_next = RESP;
`ifdef LSU_TIMEOUT_EN
        else if (timeout) state_next = RESP;
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_load_format u_load_format (
    .funct3 (f3_q),
    .offset (off_q),
    .rdata  (mem_rdata),
    .data   (fmt_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      st_q      <= 1'b0;
      ill_q     <= 1'b0;
      mis_q     <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= '0;
      load_data <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        st_q      <= is_store;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        ill_q     <= !legal;
        mis_q     <= legal && misaligned;
        mem_addr  <= {addr[WORD_SIZE-1:2], 2'b00};
        mem_be    <= be_new;
        mem_wdata <= wdata_new;
      end
      if (state == ACCESS && mem_ready && !st_q) load_data <= fmt_data;
`ifdef LSU_TIMEOUT_EN
      if (state == IDLE) tmo_cnt <= '0;
      else if (state == ACCESS && !mem_ready) tmo_cnt <= tmo_cnt + 1'b1;
      if (timeout) ill_q <= 1'b1;
`endif
    end
  end

  assign busy           = (state == ACCESS);
  assign mem_req        = (state == ACCESS);
  assign mem_we         = (state == ACCESS) && st_q;
  assign done           = (state == RESP);
  assign err_illegal    = (state == RESP) && ill_q;
  assign err_misaligned = (state == RESP) && mis_q;

endmodule
